// File: rtl/fan_pkg.sv
// Shared constants and helpers for the fan speed governor.
package fan_pkg;

    // Speed level codes as seen by the fan driver
    localparam logic [1:0] LVL_25  = 2'b00;
    localparam logic [1:0] LVL_50  = 2'b01;
    localparam logic [1:0] LVL_75  = 2'b10;
    localparam logic [1:0] LVL_100 = 2'b11;

    // Fan wiring codes
    localparam logic [1:0] LINE_2 = 2'b00;
    localparam logic [1:0] LINE_3 = 2'b01;
    localparam logic [1:0] LINE_4 = 2'b10;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SPINUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_STALL  = 2'd3
    } fan_state_e;

    // Wiring code 11 is not a real wiring option and behaves as 4-line
    function automatic logic [1:0] norm_line(input logic [1:0] cfg);
        return (cfg == 2'b11) ? LINE_4 : cfg;
    endfunction

    // a - b evaluated in 9 bits, clamped at zero
    function automatic logic [7:0] sub_clamp(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return diff[8] ? 8'd0 : diff[7:0];
    endfunction

endpackage

// File: rtl/fan_speed_ctrl_if.sv
// Control bundle from the governor to the fan driver block.
interface fan_speed_ctrl_if;

    logic       fan_switch;
    logic [1:0] pwm_choice;
    logic [1:0] power_choice;
    logic [1:0] line_choice;

    modport master (
        output fan_switch,
        output pwm_choice,
        output power_choice,
        output line_choice
    );

    modport slave (
        input fan_switch,
        input pwm_choice,
        input power_choice,
        input line_choice
    );

endinterface

// File: rtl/fan_tach_mon.sv
// Tach monitor: 2-flop synchroniser, optional glitch filter, rising-edge
// detect and per-window pulse count. Emits a one-cycle stall_pulse when a
// window closes with too few edges.
// Build option: FAN_TACH_DEBOUNCE_EN inserts a 3-tap majority filter after
// the synchroniser (2 extra cycles of latency, rejects 1-cycle glitches).
module fan_tach_mon
    import fan_pkg::*;
#(
    parameter int              CNT_W      = 24,
    parameter logic [CNT_W-1:0] TACH_WIN  = 24'd2_000_000,
    parameter logic [7:0]      MIN_PULSES = 8'd4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tach,
    input  logic win_cnt_restart,
    input  logic stall_en,
    output logic stall_pulse
);

    logic [1:0]       sync_q;
    logic             tach_f;
    logic             tach_prev;
    logic             tach_rise;
    logic [CNT_W-1:0] win_cnt;
    logic [7:0]       pulse_cnt;
    logic [7:0]       pulse_inc;
    logic             win_end;

    // Bring the asynchronous tach into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], tach};
    end

`ifdef FAN_TACH_DEBOUNCE_EN
    logic [1:0] taps_q;
    logic       filt_q;

    // Majority of three consecutive samples, registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps_q <= 2'b00;
            filt_q <= 1'b0;
        end else begin
            taps_q <= {taps_q[0], sync_q[1]};
            filt_q <= (sync_q[1] & taps_q[0]) | (sync_q[1] & taps_q[1]) | (taps_q[0] & taps_q[1]);
        end
    end

    assign tach_f = filt_q;
`else
    assign tach_f = sync_q[1];
`endif

    // Previous filtered level for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tach_prev <= 1'b0;
        else        tach_prev <= tach_f;
    end

    assign tach_rise = tach_f & ~tach_prev;
    assign pulse_inc = (tach_rise && pulse_cnt != 8'hFF) ? pulse_cnt + 8'd1 : pulse_cnt;
    assign win_end   = (win_cnt == TACH_WIN - CNT_W'(1));

    // Window timer and saturating edge count; the edge seen in the closing
    // cycle still counts toward that window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt     <= '0;
            pulse_cnt   <= 8'd0;
            stall_pulse <= 1'b0;
        end else if (win_cnt_restart) begin
            win_cnt     <= '0;
            pulse_cnt   <= 8'd0;
            stall_pulse <= 1'b0;
        end else if (win_end) begin
            win_cnt     <= '0;
            pulse_cnt   <= 8'd0;
            stall_pulse <= stall_en && (pulse_inc < MIN_PULSES);
        end else begin
            win_cnt     <= win_cnt + CNT_W'(1);
            pulse_cnt   <= pulse_inc;
            stall_pulse <= 1'b0;
        end
    end

endmodule

// File: rtl/fan_speed_ctrl.sv
// Fan speed governor: temperature-to-level mapping with hysteresis,
// rate-limited stepping, forced spin-up and tach stall recovery.
// Build option: FAN_TACH_DEBOUNCE_EN (see fan_tach_mon).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_OFF    | driver off, level 00, waiting for a fan_en rising edge
// ST_SPINUP | driver on at 100% for SPINUP_CYC cycles
// ST_RUN    | level stepped toward target, tach checked per window
// ST_STALL  | driver on at 100% for RETRY_CYC cycles, then retry spin-up
module fan_speed_ctrl
    import fan_pkg::*;
#(
    parameter int               CNT_W      = 24,
    parameter logic [CNT_W-1:0] SPINUP_CYC = 24'd1_000_000,
    parameter logic [CNT_W-1:0] STEP_CYC   = 24'd250_000,
    parameter logic [CNT_W-1:0] TACH_WIN   = 24'd2_000_000,
    parameter logic [7:0]       MIN_PULSES = 8'd4,
    parameter logic [CNT_W-1:0] RETRY_CYC  = 24'd4_000_000,
    parameter logic [7:0]       T50        = 8'd40,
    parameter logic [7:0]       T75        = 8'd55,
    parameter logic [7:0]       T100       = 8'd70,
    parameter logic [7:0]       HYST       = 8'd3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fan_en,
    input  logic [1:0]          line_cfg,
    input  logic [7:0]          temp,
    input  logic                temp_vld,
    input  logic                tach,
    input  logic                fault_clr,
    fan_speed_ctrl_if.master    drv,
    output logic [1:0]          cur_level,
    output logic                fan_fault
);

    localparam logic [1:0] S_OFF    = ST_OFF;
    localparam logic [1:0] S_SPINUP = ST_SPINUP;
    localparam logic [1:0] S_RUN    = ST_RUN;
    localparam logic [1:0] S_STALL  = ST_STALL;

    logic [1:0]       state;
    logic [1:0]       target;
    logic             fan_en_q;
    logic [CNT_W-1:0] tmr_cnt;
    logic [CNT_W-1:0] step_cnt;
    logic [1:0]       line_norm;
    logic [1:0]       line_q;
    logic             stall_pulse;
    logic             mon_restart;
    logic             stall_en;
    logic [1:0]       up_lvl;
    logic [7:0]       cur_thr;
    logic [7:0]       down_thr;
    logic             sw_q;
    logic [1:0]       pwm_q;
    logic [1:0]       pwr_q;

    assign line_norm = norm_line(line_cfg);

    // A wiring change in RUN restarts the tach window; outside RUN the
    // monitor is held clear so every RUN entry starts a fresh window
    assign mon_restart = (state != S_RUN) || (line_norm != line_q);
    assign stall_en    = (line_norm != LINE_2);

    fan_tach_mon #(
        .CNT_W      (CNT_W),
        .TACH_WIN   (TACH_WIN),
        .MIN_PULSES (MIN_PULSES)
    ) u_tach_mon (
        .clk             (clk),
        .rst_n           (rst_n),
        .tach            (tach),
        .win_cnt_restart (mon_restart),
        .stall_en        (stall_en),
        .stall_pulse     (stall_pulse)
    );

    // Candidate upward level and the hysteresis floor of the current target
    always_comb begin
        up_lvl = LVL_25;
        if (temp >= T100)     up_lvl = LVL_100;
        else if (temp >= T75) up_lvl = LVL_75;
        else if (temp >= T50) up_lvl = LVL_50;

        cur_thr = 8'd0;
        case (target)
            LVL_50:  cur_thr = T50;
            LVL_75:  cur_thr = T75;
            LVL_100: cur_thr = T100;
            default: cur_thr = 8'd0;
        endcase
        down_thr = sub_clamp(cur_thr, HYST);
    end

    // Target level: jumps up freely, drops at most one level per sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target <= LVL_25;
        end else if (temp_vld) begin
            if (up_lvl > target)
                target <= up_lvl;
            else if (target != LVL_25 && temp < down_thr)
                target <= target - 2'd1;
        end
    end

    // Registered copy of the wiring selection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) line_q <= LINE_2;
        else        line_q <= line_norm;
    end

    // Sequencer: state, applied level and its timers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_OFF;
            cur_level <= LVL_25;
            fan_en_q  <= 1'b0;
            tmr_cnt   <= '0;
            step_cnt  <= '0;
        end else begin
            fan_en_q <= fan_en;
            if (!fan_en) begin
                state     <= S_OFF;
                cur_level <= LVL_25;
                tmr_cnt   <= '0;
                step_cnt  <= '0;
            end else begin
                case (state)
                    S_OFF: begin
                        if (!fan_en_q) begin
                            state     <= S_SPINUP;
                            cur_level <= LVL_100;
                            tmr_cnt   <= '0;
                        end
                    end
                    S_SPINUP: begin
                        if (tmr_cnt == SPINUP_CYC - CNT_W'(1)) begin
                            state     <= S_RUN;
                            cur_level <= target;
                            tmr_cnt   <= '0;
                            step_cnt  <= '0;
                        end else begin
                            tmr_cnt <= tmr_cnt + CNT_W'(1);
                        end
                    end
                    S_RUN: begin
                        if (stall_pulse) begin
                            state     <= S_STALL;
                            cur_level <= LVL_100;
                            tmr_cnt   <= '0;
                            step_cnt  <= '0;
                        end else if (cur_level != target && step_cnt == STEP_CYC - CNT_W'(1)) begin
                            cur_level <= (cur_level < target) ? cur_level + 2'd1 : cur_level - 2'd1;
                            step_cnt  <= '0;
                        end else if (step_cnt != STEP_CYC - CNT_W'(1)) begin
                            // saturates so a fresh target is applied at once
                            step_cnt <= step_cnt + CNT_W'(1);
                        end
                    end
                    S_STALL: begin
                        if (tmr_cnt == RETRY_CYC - CNT_W'(1)) begin
                            state   <= S_SPINUP;
                            tmr_cnt <= '0;
                        end else begin
                            tmr_cnt <= tmr_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state     <= S_OFF;
                        cur_level <= LVL_25;
                    end
                endcase
            end
        end
    end

    // Sticky stall flag; a stall in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fan_fault <= 1'b0;
        else if (state == S_RUN && fan_en && stall_pulse)
            fan_fault <= 1'b1;
        else if (fault_clr && state != S_STALL)
            fan_fault <= 1'b0;
    end

    // Driver outputs; in OFF the driver inputs are parked at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_q  <= 1'b0;
            pwm_q <= 2'b00;
            pwr_q <= 2'b00;
        end else if (state == S_OFF) begin
            sw_q  <= 1'b0;
            pwm_q <= 2'b00;
            pwr_q <= 2'b00;
        end else if (line_norm == LINE_2) begin
            sw_q  <= 1'b1;
            pwm_q <= 2'b00;
            pwr_q <= cur_level;
        end else begin
            sw_q  <= 1'b1;
            pwm_q <= cur_level;
            pwr_q <= 2'b11;
        end
    end

    assign drv.fan_switch   = sw_q;
    assign drv.pwm_choice   = pwm_q;
    assign drv.power_choice = pwr_q;
    assign drv.line_choice  = line_q;

endmodule

// File: doc/fan_speed_ctrl.md
Name: fan_speed_ctrl

Overview:
- Closed-loop governor that sequences the fan driver block.
- Converts a temperature sample stream into a 2-bit speed level, with hysteresis and rate-limited ramping.
- Forces a full-speed spin-up on enable and detects rotor stall from the tach input.
- Drives the driver's `fan_switch`, `pwm_choice`, `power_choice` and `line_choice` inputs directly; sits between the thermal sensor interface and the fan driver.

Parameters:
- `CNT_W`, 24: width of all cycle counters.
- `SPINUP_CYC`, 24'd1_000_000: cycles at forced 100% after enable or after a stall retry.
- `STEP_CYC`, 24'd250_000: minimum cycles between one-level speed changes.
- `TACH_WIN`, 24'd2_000_000: tach measurement window, in cycles.
- `MIN_PULSES`, 8'd4: minimum tach rising edges per window; fewer edges means stall.
- `RETRY_CYC`, 24'd4_000_000: cycles held in STALL before a restart attempt.
- `T50`, 8'd40: temperature threshold for level 01 (50%).
- `T75`, 8'd55: temperature threshold for level 10 (75%).
- `T100`, 8'd70: temperature threshold for level 11 (100%).
- `HYST`, 8'd3: hysteresis in degrees for downward transitions.

Ports:
- `clk` in 1: single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `fan_en` in 1: governor enable.
- `line_cfg` in 2: fan wiring. 00 = 2-line, 01 = 3-line, 10 = 4-line, 11 treated as 10.
- `temp` in 8: unsigned temperature in degrees C.
- `temp_vld` in 1: one-cycle strobe qualifying `temp`.
- `tach` in 1: asynchronous tach pulse from the fan.
- `fault_clr` in 1: pulse that clears the sticky fault.
- `fan_switch` out 1: to driver.
- `pwm_choice` out 2: to driver.
- `power_choice` out 2: to driver.
- `line_choice` out 2: to driver; registered copy of `line_cfg`.
- `cur_level` out 2: currently applied speed level.
- `fan_fault` out 1: sticky stall flag.

Behaviour:
- **Reset values:** `rst_n` low clears every register asynchronously. `fan_switch`=0, `pwm_choice`=00, `power_choice`=00, `line_choice`=00, `cur_level`=00, `fan_fault`=0, state=OFF, target=00, all counters=0.
- **Level codes:** 00=25%, 01=50%, 10=75%, 11=100%.
- **Target level:** updated only on `temp_vld`, one cycle after the strobe.
  - Upward: the target becomes the highest level whose threshold satisfies `temp >= T`.
  - Downward: the target drops one level only if `temp < T_current - HYST`. Compute the subtraction in 9 bits and clamp at 0.
  - Only one downward level change per sample.
- **Output mapping** (registered, 1-cycle latency from `cur_level`/state):
  - `line_cfg`=00: `power_choice` = level, `pwm_choice` = 00.
  - Otherwise: `power_choice` = 11, `pwm_choice` = level.
- **State OFF:**
  - `fan_switch`=0, `cur_level`=00.
  - `fan_en` rising → SPINUP.
- **State SPINUP:**
  - `fan_switch`=1, applied level forced to 11.
  - After `SPINUP_CYC` cycles: `cur_level` is set to the target, then → RUN.
- **State RUN:**
  - If `cur_level` != target, step it one level toward the target once the step counter reaches `STEP_CYC`. The step counter resets on each step.
  - Tach is synchronised with 2 flops, then rising-edge detected; an 8-bit saturating edge counter runs per window.
  - At window end, if count < `MIN_PULSES` and `line_cfg` != 00: → STALL and set `fan_fault`=1.
  - The window counter and edge counter restart at every window end and on RUN entry.
  - 2-line fans (`line_cfg`=00) have no tach, so stall detection is disabled.
- **State STALL:**
  - `fan_switch`=1, level forced to 11.
  - After `RETRY_CYC` cycles → SPINUP.
- **Disable:** `fan_en` low in any state → OFF on the next edge. Counters clear; `fan_fault` is retained.
- **Fault clear:** `fault_clr` clears `fan_fault` only in OFF/SPINUP/RUN. A stall detection in the same cycle as `fault_clr` wins.
- **Config change:** a `line_cfg` change while in RUN restarts the tach window.

Optional Feature:
- Macro: `FAN_TACH_DEBOUNCE_EN`.
- **Defined:** a 3-tap majority filter follows the synchroniser. It adds 2 cycles of tach latency and rejects single-cycle glitches.
- **Undefined:** raw synchroniser output feeds the edge detector.

Decomposition:
- **Package `fan_pkg`:**
  - Level localparams `LVL_25`, `LVL_50`, `LVL_75`, `LVL_100`.
  - Line localparams `LINE_2`, `LINE_3`, `LINE_4`.
  - State enum: `ST_OFF`, `ST_SPINUP`, `ST_RUN`, `ST_STALL`.
- **Sub-module `fan_tach_mon`:** synchroniser, optional filter, edge detect, window and pulse counters. Outputs a one-cycle `stall_pulse` and a `win_cnt_restart` input.

Test Plan:
- **Spin-up:** reset with `SPINUP_CYC`=10, `fan_en`=1, `line_cfg`=10, `temp`=30 → `fan_switch`=1 and `pwm_choice`=11 for 10 cycles, then `pwm_choice`=00 and `power_choice`=11.
- **Ramp up:** in RUN at level 00, `temp`=72 with `STEP_CYC`=5 → `cur_level` goes 01, 10, 11 at 5-cycle intervals.
- **Hysteresis:** at level 11, `temp`=68 → level stays 11; `temp`=66 → target 10, applied after one step interval.
- **Stall:** `TACH_WIN`=20, `MIN_PULSES`=4, 2 tach pulses per window, `line_cfg`=01 → STALL, `fan_fault`=1, level forced to 11. After `RETRY_CYC` → SPINUP. `fault_clr` then clears the fault.
- **2-line fan:** `line_cfg`=00, no tach → no stall; `power_choice` tracks `cur_level`, `pwm_choice`=00.
- **Async reset:** `rst_n` low mid-RUN → all outputs 0 immediately, with no clock edge required.
